imem_arbiter: RTL

Shares the single combinational instruction memory port between two requesters: CPU instruction fetch (IF) and a debug/program-dump port (DBG). Accepts at most one request per cycle, drives the memory address, registers the returned word, and routes it to the winner one cycle later. Fetch has priority, and a starvation guard guarantees DBG progress. Sits between the fetch stage/debug unit and the instruction memory.

---
 rtl/imem_arb_pkg.sv | 19 +
 rtl/imem_arb_starve_ctr.sv | 30 +++
 rtl/imem_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// Contents: owner encoding, NOP word, starve counter width, address check helper.
package imem_arb_pkg;

    localparam int unsigned STARVE_CNT_W = 4;
    localparam logic [31:0] NOP_INST     = 32'h0000_0000;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    // Misaligned, or any bit at or above addr_width set.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned addr_width);
        return (addr[1:0] != 2'b00) || ((addr >> addr_width) != 32'd0);
    endfunction

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Saturating count of IF grants made while DBG waits.
// Ports: clk, reset (async, active-low), clr, inc -> hit_c (count reached STARVE_LIMIT).
module imem_arb_starve_ctr
    import imem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic hit_c
);

    logic [STARVE_CNT_W-1:0] cnt;

    // Clear wins over increment; saturate at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + STARVE_CNT_W'(1);
        end
    end

    assign hit_c = (cnt >= STARVE_CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single combinational instruction memory port between fetch (IF)
// and debug (DBG). One-cycle response latency, IF priority with a DBG starvation guard.
// Ports: clk, reset (async, active-low); IF and DBG request/response channels;
// mem_addr/mem_inst memory port. Optional IMEM_ARB_STATS_EN adds if_grant_cnt and
// dbg_grant_cnt accept counters.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_inst,
    output logic        if_resp_err,
    input  logic        dbg_req_valid,
    output logic        dbg_req_ready,
    input  logic [31:0] dbg_addr,
    output logic        dbg_resp_valid,
    output logic [31:0] dbg_resp_inst,
    output logic        dbg_resp_err,
`ifdef IMEM_ARB_STATS_EN
    output logic [15:0] if_grant_cnt,
    output logic [15:0] dbg_grant_cnt,
`endif
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_inst
);

    owner_e      owner_q, owner_d;
    logic        starve_hit;
    logic        if_win, dbg_win, any_grant, grant_bad;
    logic [31:0] grant_addr;
    logic [31:0] last_addr_q;
    logic [31:0] inst_q;
    logic        err_q;

    imem_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .clr   (dbg_win || !dbg_req_valid),
        .inc   (if_win && dbg_req_valid),
        .hit_c (starve_hit)
    );

    // IF wins a contested cycle unless DBG has waited STARVE_LIMIT grants.
    always_comb begin
        if_win     = if_req_valid && !(dbg_req_valid && starve_hit);
        dbg_win    = dbg_req_valid && !if_win;
        any_grant  = if_win || dbg_win;
        grant_addr = dbg_win ? dbg_addr : if_addr;
        grant_bad  = addr_bad(grant_addr, ADDR_WIDTH);
    end

    assign if_req_ready  = if_win;
    assign dbg_req_ready = dbg_win;
    // Idle cycles replay the last address so the memory input stays quiet.
    assign mem_addr      = any_grant ? grant_addr : last_addr_q;

    // Owner state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) owner_q <= OWN_NONE;
        else        owner_q <= owner_d;
    end

    // Owner next state: whoever was granted this cycle.
    always_comb begin
        owner_d = OWN_NONE;
        if (if_win)       owner_d = OWN_IF;
        else if (dbg_win) owner_d = OWN_DBG;
    end

    // Response capture; bad addresses return NOP with err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_q      <= NOP_INST;
            err_q       <= 1'b0;
            last_addr_q <= '0;
        end else if (any_grant) begin
            inst_q      <= grant_bad ? NOP_INST : mem_inst;
            err_q       <= grant_bad;
            last_addr_q <= grant_addr;
        end
    end

    always_comb begin
        if_resp_valid  = (owner_q == OWN_IF);
        dbg_resp_valid = (owner_q == OWN_DBG);
        if_resp_inst   = if_resp_valid  ? inst_q : NOP_INST;
        dbg_resp_inst  = dbg_resp_valid ? inst_q : NOP_INST;
        if_resp_err    = if_resp_valid  && err_q;
        dbg_resp_err   = dbg_resp_valid && err_q;
    end

`ifdef IMEM_ARB_STATS_EN
    // Accept counters, free-running with natural wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_grant_cnt  <= '0;
            dbg_grant_cnt <= '0;
        end else begin
            if (if_win)  if_grant_cnt  <= if_grant_cnt + 16'd1;
            if (dbg_win) dbg_grant_cnt <= dbg_grant_cnt + 16'd1;
        end
    end
`endif

endmodule
